main_controller: RTL

MAIN_CONTROLLER -- requirements
Module: main_controller

---
 rtl/main_controller.sv | 129 ++++++++++++
 1 files changed

// File: rtl/main_controller.sv
// Multicycle RISC-V main control FSM: sequences fetch/decode/execute/writeback
// and drives datapath selects and write enables as a Moore machine.
module main_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic [3:0] State,
    output logic       InstrDone
);
    localparam logic [3:0] FETCH     = 4'd0;
    localparam logic [3:0] DECODE    = 4'd1;
    localparam logic [3:0] MEMADR    = 4'd2;
    localparam logic [3:0] MEMREAD   = 4'd3;
    localparam logic [3:0] MEMWB     = 4'd4;
    localparam logic [3:0] MEMWRITE  = 4'd5;
    localparam logic [3:0] EXECUTER  = 4'd6;
    localparam logic [3:0] ALUWB     = 4'd7;
    localparam logic [3:0] EXECUTEI  = 4'd8;
    localparam logic [3:0] JAL       = 4'd9;
    localparam logic [3:0] BEQ       = 4'd10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    logic [3:0] state, next_state;
    logic       run;
    logic       pc_update, branch, ir_w, mem_w, reg_w, done;
    logic [1:0] imm_dec;

    // run stays low through reset and the first edge after it, so Fetch is
    // held one full cycle before sequencing starts and no write leaks early.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            run   <= 1'b0;
        end else begin
            run   <= 1'b1;
            state <= run ? next_state : FETCH;
        end
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:    next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_R:         next_state = EXECUTER;
                    OP_I:         next_state = EXECUTEI;
                    OP_JAL:       next_state = JAL;
                    OP_BEQ:       next_state = BEQ;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR:   next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  next_state = MEMWB;
            EXECUTER, EXECUTEI, JAL: next_state = ALUWB;
            default:  next_state = FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   imm_dec = 2'b01;
            OP_BEQ:  imm_dec = 2'b10;
            OP_JAL:  imm_dec = 2'b11;
            default: imm_dec = 2'b00;
        endcase
    end

    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        ir_w      = 1'b0;
        mem_w     = 1'b0;
        reg_w     = 1'b0;
        done      = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 2'b00;
        ImmSrc    = imm_dec;
        case (state)
            FETCH: begin
                ir_w = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; pc_update = 1'b1;
            end
            DECODE: begin
                ALUSrcA = 2'b01; ALUSrcB = 2'b01;
                done = !(op inside {OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ});
            end
            MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB:    begin ResultSrc = 2'b01; reg_w = 1'b1; done = 1'b1; end
            MEMWRITE: begin AdrSrc = 1'b1; mem_w = 1'b1; done = 1'b1; end
            EXECUTER: begin ALUSrcA = 2'b10; ALUOp = 2'b10; end
            EXECUTEI: begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUOp = 2'b10; end
            ALUWB:    begin reg_w = 1'b1; done = 1'b1; end
            JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; pc_update = 1'b1; end
            BEQ: begin
                ALUSrcA = 2'b10; ALUOp = 2'b01; branch = 1'b1; done = 1'b1;
            end
            default:  ImmSrc = 2'b00;
        endcase
    end

    assign PCWrite   = run & (pc_update | (branch & Zero));
    assign IRWrite   = run & ir_w;
    assign MemWrite  = run & mem_w;
    assign RegWrite  = run & reg_w;
    assign InstrDone = run & done;
    assign State     = state;
endmodule
